// File: rtl/song_sequencer.sv
// song_sequencer: auto-play controller feeding the buzzer tone generator.
// It walks a song memory of (note, pitch, duration) entries. Each note plays
// for duration*unit - GAP_CYCLES cycles and is followed by GAP_CYCLES of silence.
// Optional feature macro: TEMPO_SCALE_EN adds tempo_sel[1:0], which scales the
// unit length for each entry.
module song_sequencer #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              stop_req,
    input  logic              loop_en,
`ifdef TEMPO_SCALE_EN
    input  logic [1:0]        tempo_sel,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [6:0]        note,
    output logic [2:0]        pitch,
    output logic              buzz_stop,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] song_pos
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [6:0]        note_q, note_d;
    logic [2:0]        pitch_q, pitch_d;
    logic              rest_q, rest_d;
    logic [35:0]       cnt_q, cnt_d;

    logic [35:0]       unit_len;
    logic [35:0]       play_len;
    logic [3:0]        dur;
    logic              pitch_ok;
    logic              next_is_end;
    logic              rsvd_unused;

    assign dur         = rom_data[13:10];
    assign pitch_ok    = (rom_data[9:7] == 3'b001) || (rom_data[9:7] == 3'b010) ||
                         (rom_data[9:7] == 3'b100);
    assign rsvd_unused = ^rom_data[15:14];

`ifdef TEMPO_SCALE_EN
    // Per-entry unit length chosen by tempo_sel; the gap is never scaled.
    always_comb begin
        case (tempo_sel)
            2'b01:   unit_len = 36'(BEAT_CYCLES) << 1;
            2'b10:   unit_len = 36'(BEAT_CYCLES / 2);
            default: unit_len = 36'(BEAT_CYCLES);
        endcase
    end
`else
    assign unit_len = 36'(BEAT_CYCLES);
`endif

    // Sounding part of a note: full 36-bit product minus the trailing gap.
    assign play_len = (36'(dur) * unit_len) - 36'(GAP_CYCLES);

    // rom_addr already points at the next entry while the current one plays,
    // so rom_data on the last gap cycle reveals an end marker with no extra fetch.
    // The last address never advances, so rom_addr cannot wrap silently.
    assign next_is_end = (pos_q == '1) || (dur == 4'd0);

    // Next-state, counter and latched-entry logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pos_d   = pos_q;
        note_d  = note_q;
        pitch_d = pitch_q;
        rest_d  = rest_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                end
            end
            S_FETCH: begin
                if (!pause) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (!pause) begin
                    if (dur == 4'd0) begin
                        if (loop_en) begin
                            state_d = S_FETCH;
                            addr_d  = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        state_d = S_PLAY;
                        note_d  = rom_data[6:0];
                        pitch_d = rom_data[9:7];
                        rest_d  = (rom_data[6:0] == 7'd0) || !pitch_ok;
                        pos_d   = addr_q;
                        cnt_d   = play_len;
                        addr_d  = (addr_q == '1) ? addr_q : addr_q + ADDR_W'(1);
                    end
                end
            end
            S_PLAY: begin
                if (!pause) begin
                    if (cnt_q == 36'd1) begin
                        state_d = S_GAP;
                        cnt_d   = 36'(GAP_CYCLES);
                    end else begin
                        cnt_d = cnt_q - 36'd1;
                    end
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt_q == 36'd1) begin
                        if (!next_is_end) begin
                            state_d = S_FETCH;
                        end else if (loop_en) begin
                            state_d = S_FETCH;
                            addr_d  = '0;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else begin
                        cnt_d = cnt_q - 36'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase
        // Abort beats pause and start in the same cycle.
        if (stop_req && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            addr_d  = '0;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            pos_q   <= '0;
            note_q  <= 7'd0;
            pitch_q <= 3'd0;
            rest_q  <= 1'b1;
            cnt_q   <= 36'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pos_q   <= pos_d;
            note_q  <= note_d;
            pitch_q <= pitch_d;
            rest_q  <= rest_d;
            cnt_q   <= cnt_d;
        end
    end

    // Tone outputs are live only in PLAY, for a real note, while not paused.
    always_comb begin
        note      = 7'd0;
        pitch     = 3'd0;
        buzz_stop = 1'b1;
        if ((state_q == S_PLAY) && !pause && !rest_q) begin
            note      = note_q;
            pitch     = pitch_q;
            buzz_stop = 1'b0;
        end
    end

    assign rom_addr = addr_q;
    assign song_pos = pos_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Auto-play controller for the piano's buzzer tone generator.
- Walks a song memory of (note, pitch, duration) entries and drives the tone generator's note, pitch and stop inputs with exact per-note timing and a short silent articulation gap between notes.
- Supports pause/resume, abort, looping and rests.
- Sits between the top-level mode controller and the buzzer; the mode controller selects whether the buzzer is fed by the switches or by this block.

Parameters:
- BEAT_CYCLES, 12500000, clk cycles per duration unit (125 ms at 100 MHz).
- GAP_CYCLES, 5000000, silent cycles at the end of each note; must satisfy 0 < GAP_CYCLES < BEAT_CYCLES.
- ADDR_W, 8, song memory address width.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins playback from address 0.
- pause  in  1  level; while high, playback freezes and output is silent.
- stop_req  in  1  one-cycle pulse; aborts playback.
- loop_en  in  1  level; replay from address 0 at end of song.
- rom_addr  out  ADDR_W  song memory read address.
- rom_data  in  16  entry data, valid one cycle after rom_addr. Fields: [6:0] note (one-hot, same encoding as buzzer), [9:7] pitch (one-hot: 001 low, 010 mid, 100 high), [13:10] duration in units, [15:14] reserved.
- note  out  7  to buzzer note.
- pitch  out  3  to buzzer pitch.
- buzz_stop  out  1  to buzzer stop; 1 = silent.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on natural song end.
- song_pos  out  ADDR_W  address of the entry currently sounding.

Behaviour:
- Reset values: rom_addr=0, note=0, pitch=0, buzz_stop=1, busy=0, done=0, song_pos=0, FSM=IDLE.
- States:
  - IDLE -> FETCH on start.
  - FETCH: rom_addr holds the entry address.
  - LOAD: rom_data latched and decoded.
  - PLAY, then GAP, then FETCH of the next address.
  - DONE: done=1 for one cycle, then IDLE.
- Latency: start sampled at edge k; FETCH at k+1; LOAD at k+2; PLAY outputs visible from k+3.
- Durations:
  - PLAY lasts duration*BEAT_CYCLES - GAP_CYCLES cycles; GAP lasts GAP_CYCLES.
  - Note period equals duration*BEAT_CYCLES + 2 cycles (FETCH and LOAD overhead).
  - Duration product is computed at 36 bits with no truncation.
- Output values by state:
  - PLAY: note/pitch = latched fields, buzz_stop=0.
  - All other states: note=0, pitch=0, buzz_stop=1.
- Rest: an entry with note==0, or pitch not exactly one-hot, is a rest. It is silent for the full duration, still includes the gap, and song_pos still updates.
- End of song:
  - duration==0 is the end marker.
  - loop_en=1: next fetch is at address 0 with no extra cycle; done is not pulsed.
  - loop_en=0: DONE.
  - After the entry at address 2^ADDR_W-1 finishes its gap, the next address is treated as an end marker; rom_addr never wraps silently.
- Pause:
  - Sampled every cycle in PLAY, GAP, FETCH and LOAD.
  - While high, state and counters freeze and outputs are silent.
  - On release, the remaining count continues; total sounding cycles are unchanged.
  - Pause in IDLE has no effect.
- Stop:
  - stop_req in any non-IDLE state goes to IDLE on the next edge; outputs are silent and done is not pulsed.
  - stop_req overrides pause and start in the same cycle.
  - start while busy is ignored.
- rst mid-operation: all outputs return to reset values on the next edge.

Optional Feature:
- Macro TEMPO_SCALE_EN.
- Defined:
  - Adds input tempo_sel[1:0], sampled in LOAD for each entry.
  - Unit length: 00 -> BEAT_CYCLES, 01 -> 2*BEAT_CYCLES, 10 -> BEAT_CYCLES/2 (floor), 11 -> BEAT_CYCLES.
  - GAP_CYCLES is unscaled.
  - BEAT_CYCLES/2 must exceed GAP_CYCLES.
- Undefined: the port is absent and the unit is always BEAT_CYCLES.

Test Plan (BEAT_CYCLES=10, GAP_CYCLES=3, ADDR_W=4):
- ROM[0]={note=0000001, pitch=010, dur=2}, ROM[1]=end, start at edge 0 -> note=0000001, pitch=010, buzz_stop=0 for 17 cycles from edge 3; silent 3 cycles; done pulse exactly once; busy=0 after.
- Same ROM with loop_en=1 -> rom_addr returns to 0 with no done pulse and the tone repeats every 22 cycles; drop loop_en -> one done pulse after the current pass.
- pause high for 5 cycles starting at the 6th PLAY cycle -> silent for those 5 cycles, then the tone resumes; total tone cycles = 17; done is delayed by 5 cycles.
- stop_req and start asserted together during PLAY -> next edge: IDLE, buzz_stop=1, busy=0; done never pulses; new start afterwards plays from address 0.
- ROM[0]={note=0, dur=1}, ROM[1]={note=0000100, pitch=011, dur=1}, ROM[2]={note=0000100, pitch=001, dur=1} -> 24 silent cycles with song_pos stepping 0 then 1, then tone note=0000100, pitch=001.
- rst asserted mid-PLAY -> next edge: all outputs at reset values; no done pulse.
